// File: rtl/umul_bi_array.sv
// umul_bi_array: N-channel bipolar unary multiplier; weights commit at 2^W-cycle window wraps.
// Define UMUL_BI_ACC_EN to add the per-window ones counters (oAcc, oAccValid).
module umul_bi_array #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N-1:0]       iA,
    input  logic [N*W-1:0]     wData,
    input  logic               wValid,
    output logic               wReady,
    output logic [N-1:0]       oC,
    output logic               oWinDone
`ifdef UMUL_BI_ACC_EN
    ,
    output logic [N*(W+1)-1:0] oAcc,
    output logic               oAccValid
`endif
);
    typedef enum logic {EMPTY, RUN} state_t;
    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [W-1:0]        win_q, win_d;
    logic [N-1:0][W-1:0] w_sh_q, w_sh_d, w_act_q, w_act_d;
    logic [N-1:0][W-1:0] cnt_f_q, cnt_f_d, cnt_r_q, cnt_r_d;
    logic                done_q;
    logic                run, accept, wrap, commit;

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    assign wReady = ~pending_q;

    always_comb begin
        run       = state_q == RUN;
        accept    = wValid & ~pending_q;
        wrap      = run & en & (&win_q);
        commit    = pending_q & (~run | wrap);
        state_d   = commit ? RUN : state_q;
        pending_d = accept | (pending_q & ~commit);
        w_sh_d    = accept ? wData : w_sh_q;
        w_act_d   = commit ? w_sh_q : w_act_q;
        win_d     = commit ? '0 : win_q + W'(run & en);
        oC        = '0;
        cnt_f_d   = cnt_f_q;
        cnt_r_d   = cnt_r_q;
        for (int c = 0; c < N; c++) begin
            cnt_f_d[c] = commit ? '0 : cnt_f_q[c] + W'(run & en & iA[c]);
            cnt_r_d[c] = commit ? '0 : cnt_r_q[c] + W'(run & en & ~iA[c]);
            oC[c] = run & en & (iA[c] ? (w_act_q[c] > rev(cnt_f_q[c])) : (w_act_q[c] <= rev(cnt_r_q[c])));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            pending_q <= 1'b0;
            win_q     <= '0;
            w_sh_q    <= '0;
            w_act_q   <= '0;
            cnt_f_q   <= '0;
            cnt_r_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            win_q     <= win_d;
            w_sh_q    <= w_sh_d;
            w_act_q   <= w_act_d;
            cnt_f_q   <= cnt_f_d;
            cnt_r_q   <= cnt_r_d;
            done_q    <= wrap;
        end
    end

    assign oWinDone = done_q;

`ifdef UMUL_BI_ACC_EN
    logic [N-1:0][W:0] ones_q, ones_d, acc_q, acc_d;

    // The wrap cycle's own product bit is folded into the reported count.
    always_comb begin
        ones_d = ones_q;
        acc_d  = acc_q;
        for (int c = 0; c < N; c++) begin
            ones_d[c] = wrap ? '0 : ones_q[c] + (W+1)'(oC[c]);
            acc_d[c]  = wrap ? ones_q[c] + (W+1)'(oC[c]) : acc_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
            acc_q  <= '0;
        end else begin
            ones_q <= ones_d;
            acc_q  <= acc_d;
        end
    end

    assign oAcc      = acc_q;
    assign oAccValid = done_q;
`endif
endmodule

// File: tb/tb_umul_bi_array.sv
// tb_umul_bi_array: random and directed stimulus against a behavioural bipolar-multiplier model.
module tb_umul_bi_array;
    localparam int N = 4;
    localparam int W = 4;
    localparam int L = 1 << W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           wValid = 1'b0;
    logic [N-1:0]   iA = '0;
    logic [N*W-1:0] wData = '0;
    logic           wReady;
    logic [N-1:0]   oC;
    logic           oWinDone;
`ifdef UMUL_BI_ACC_EN
    logic [N*(W+1)-1:0] oAcc;
    logic               oAccValid;
`endif

    int checks = 0;
    int failures = 0;

    int m_act[N], m_sh[N], m_nf[N], m_nr[N], m_ones[N], m_acc[N];
    bit m_pend, m_run, m_done;
    int m_win;
    int obs_ones[N];
    int done_cnt, tick;

    always #5 clk = ~clk;

    umul_bi_array #(.N(N), .W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .iA(iA),
        .wData(wData),
        .wValid(wValid),
        .wReady(wReady),
        .oC(oC),
        .oWinDone(oWinDone)
`ifdef UMUL_BI_ACC_EN
        ,
        .oAcc(oAcc),
        .oAccValid(oAccValid)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rev(input int v);
        int r = 0;
        for (int i = 0; i < W; i++) if (((v >> i) & 1) != 0) r |= 1 << (W - 1 - i);
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_act[c] = 0; m_sh[c] = 0; m_nf[c] = 0; m_nr[c] = 0; m_ones[c] = 0; m_acc[c] = 0;
        end
        m_pend = 0; m_run = 0; m_done = 0; m_win = 0;
    endtask

    task automatic check_outputs(input bit [N-1:0] ec);
        chk("oC", oC, ec);
        chk("wReady", wReady, !m_pend);
        chk("oWinDone", oWinDone, m_done);
`ifdef UMUL_BI_ACC_EN
        chk("oAccValid", oAccValid, m_done);
        for (int c = 0; c < N; c++) chk("oAcc", oAcc[c*(W+1) +: W+1], m_acc[c]);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; wValid = 1'b0; iA = '0; wData = '0;
        #1;
        model_reset();
        check_outputs('0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit e, input bit [N-1:0] a, input bit v, input bit [N*W-1:0] d);
        bit [N-1:0] ec;
        bit acc, wrap, commit;
        @(negedge clk);
        en = e; iA = a; wValid = v; wData = d;
        #1;
        for (int c = 0; c < N; c++)
            ec[c] = e && m_run && (a[c] ? (m_act[c] > rev(m_nf[c])) : (m_act[c] <= rev(m_nr[c])));
        check_outputs(ec);
        for (int c = 0; c < N; c++) obs_ones[c] += int'(oC[c]);
        done_cnt += int'(oWinDone);
        tick++;
        acc    = v && !m_pend;
        wrap   = m_run && e && m_win == L - 1;
        commit = m_pend && (!m_run || wrap);
        if (m_run && e) begin
            m_win = (m_win + 1) % L;
            for (int c = 0; c < N; c++)
                if (a[c]) m_nf[c] = (m_nf[c] + 1) % L;
                else      m_nr[c] = (m_nr[c] + 1) % L;
        end
        for (int c = 0; c < N; c++) begin
            m_ones[c] += int'(ec[c]);
            if (wrap) begin
                m_acc[c] = m_ones[c];
                m_ones[c] = 0;
            end
        end
        if (commit) begin
            for (int c = 0; c < N; c++) begin
                m_act[c] = m_sh[c]; m_nf[c] = 0; m_nr[c] = 0;
            end
            m_pend = 0; m_run = 1; m_win = 0;
        end
        if (acc) begin
            for (int c = 0; c < N; c++) m_sh[c] = int'(d[c*W +: W]);
            m_pend = 1;
        end
        m_done = wrap;
    endtask

    initial begin
        int d0, first_pulse, last_pulse;
        model_reset();
        done_cnt = 0; tick = 0;
        for (int c = 0; c < N; c++) obs_ones[c] = 0;
        do_reset();

        // Weights {8,0,15,15} against iA {1,0,1,0}: 8, 16, 15 and 1 ones per window.
        step(0, '0, 1, {4'd15, 4'd15, 4'd0, 4'd8});
        step(0, '0, 0, '0);
        for (int c = 0; c < N; c++) obs_ones[c] = 0;
        d0 = done_cnt;
        for (int k = 0; k < L; k++) step(1, 4'b0101, 0, '0);
        chk("ones_w8_a1", obs_ones[0], 8);
        chk("ones_w0_a0", obs_ones[1], 16);
        chk("ones_w15_a1", obs_ones[2], 15);
        chk("ones_w15_a0", obs_ones[3], 1);
        step(0, '0, 0, '0);
        chk("one_pulse", done_cnt - d0, 1);

        // Load at window cycle 5; commit waits for the wrap.
        while (m_win != 5) step(1, N'($urandom), 0, '0);
        step(1, N'($urandom), 1, {4'd4, 4'd4, 4'd4, 4'd4});
        step(1, N'($urandom), 0, '0);
        chk("wready_low", wReady, 0);
        while (m_win != 0) step(1, N'($urandom), 0, '0);
        step(1, N'($urandom), 0, '0);
        chk("wready_back", wReady, 1);

        // Alternate en: window spans 32 clocks.
        first_pulse = -1; last_pulse = -1;
        for (int k = 0; k < 80; k++) begin
            step(k % 2 == 0, N'($urandom), 0, '0);
            if (oWinDone === 1'b1) begin
                first_pulse = last_pulse;
                last_pulse = tick;
            end
        end
        chk("win_32clk", last_pulse - first_pulse, 32);

        // Reset at window cycle 7 with a load pending.
        while (m_win != 2) step(1, N'($urandom), 0, '0);
        step(1, N'($urandom), 1, N*W'($urandom));
        while (m_win != 7) step(1, N'($urandom), 0, '0);
        chk("pend_before_rst", wReady, 0);
        do_reset();
        d0 = done_cnt;
        for (int k = 0; k < 20; k++) step(1, N'($urandom), 0, '0);
        chk("no_pulse_after_rst", done_cnt - d0, 0);
        step(1, N'($urandom), 1, N*W'($urandom));
        for (int k = 0; k < L + 2; k++) step(1, N'($urandom), 0, '0);
        chk("pulse_after_reload", done_cnt - d0, 1);

        // wValid held high for several windows.
        for (int k = 0; k < 4 * L; k++) step(1, N'($urandom), 1, N*W'($urandom));

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 3) != 0, N'($urandom), $urandom_range(0, 4) == 0, N*W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/umul_bi_array.md
# umul_bi_array

Parametrised, multi-channel bipolar unary multiplier for the stochastic-computing datapath. Each of N channels multiplies an incoming bipolar bitstream by a W-bit binary weight and emits a bipolar product bitstream. Weights arrive through a valid/ready handshake into shadow registers and commit only at window boundaries, so the weight is constant across every 2^W-cycle window. The block sits between the bitstream generators and the downstream unary adders and accumulators, and replaces the single-channel, fixed-width multiplier.

## Interface
- N, default 4: number of independent channels.
- W, default 8: weight width. Window length is 2^W enabled cycles.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  advance enable; when low, all state holds.
- iA  in  N  input bipolar bitstreams, one bit per channel.
- wData  in  N*W  weights; channel c is at bits [c*W +: W], unsigned, p = w/2^W.
- wValid  in  1  weight vector valid.
- wReady  out  1  shadow register free.
- oC  out  N  product bitstreams.
- oWinDone  out  1  one-cycle pulse after each completed window.
- oAcc  out  N*(W+1)  ones count per channel for the last window. Present only with UMUL_BI_ACC_EN.
- oAccValid  out  1  oAcc update strobe. Present only with UMUL_BI_ACC_EN.

## Operation
- Active weight wAct[c] and shadow weight wSh[c]; pending flag marks that the shadow holds uncommitted data.
- wReady = ~pending. A load is accepted when wValid & wReady; on acceptance, wSh <= wData and pending <= 1.
- State EMPTY (reset state): no weight has been committed yet.
  - oC = 0; counters hold.
  - A pending shadow commits on the next edge: wAct <= wSh, pending <= 0, state -> RUN, all counters cleared.
- State RUN:
  - winCnt (W bits) increments on every en cycle.
  - Wrap: en & winCnt == 2^W-1. On the wrap edge, winCnt -> 0. If pending is set, the commit happens on the same edge and clears the per-channel RNG counters.
- A load accepted on the wrap cycle only fills the shadow (pending was 0 on that cycle). It commits at the following wrap; there is no bypass.
- Per channel c:
  - Forward counter cntF increments on en & iA[c]; rngF = bit-reverse(cntF). This is the van der Corput / Sobol dim-1 sequence.
  - Reverse counter cntR increments on en & ~iA[c]; rngR = bit-reverse(cntR).
  - oC[c] = en & RUN & ((iA[c] & wAct[c] > rngF) | (~iA[c] & wAct[c] <= rngR)).
  - Comparisons are unsigned, W bits. Counters wrap modulo 2^W.
- Result: P(oC) = pA*pB + (1-pA)(1-pB), which is the bipolar product.

## Timing
- oC is combinational from iA, en and registered state: 0-cycle latency.
- oWinDone is registered. It is high for exactly the one cycle after each wrap edge, and never in EMPTY.
- Weight latency: from acceptance to effect is at most 2^W enabled cycles in RUN, or 1 cycle in EMPTY.
- en low:
  - winCnt, cntF and cntR hold; oC = 0.
  - The handshake still operates; a commit from EMPTY still occurs.
- Reset values:
  - oC = 0, oWinDone = 0, wReady = 1.
  - oAcc = 0, oAccValid = 0.
  - All registers 0, state EMPTY.
- Asserting rst_n low mid-window aborts that window. No oWinDone pulse is produced for it, and any pending shadow is discarded.

## Configuration
- UMUL_BI_ACC_EN defined: each channel has a (W+1)-bit counter of oC ones, cleared at each wrap.
  - At the wrap edge, oAcc[c] <= count + oC[c] (the count including the wrap cycle's own bit); range 0..2^W.
  - oAccValid pulses together with oWinDone.
- UMUL_BI_ACC_EN undefined: the oAcc and oAccValid ports and the per-channel counters are absent. All other behaviour is identical.

## Test plan
- W=4, N=1: load w=8, then hold iA=1 for 16 en cycles -> exactly 8 ones on oC, oWinDone pulses once, oAcc=8.
- Load w=0 with iA=0 -> 16 ones, oAcc=16. Load w=15 with iA=1 -> 15 ones. Load w=15 with iA=0 -> 1 one.
- Load w=4 at window cycle 5 -> wReady drops the cycle after acceptance, old weight persists through cycle 15, new weight is active from cycle 0 of the next window, and wReady returns to 1 after the wrap.
- With N=4, apply 4 different weights and independent iA streams; deassert en on alternate cycles -> oC=0 on stalled cycles, per-channel counts match the reference model, and each window spans 32 clocks.
- Assert rst_n low at window cycle 7 with a load pending -> all outputs 0 and wReady=1 immediately; after release, state is EMPTY and no oWinDone occurs until a new load plus 16 en cycles.
- wValid held high continuously -> one acceptance per window, commits exactly at the wraps, and no weight is lost or applied twice.
